// File: rtl/seq_divider.sv
// Iterative restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// start/busy/done handshake; Q, R and DZ hold until the next operation completes.
module seq_divider #(
    parameter int unsigned W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*W-1:0]   X,
    input  logic [W-1:0]     Y,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   Q,
    output logic [W-1:0]     R,
    output logic             DZ
);

    localparam int unsigned CW = $clog2(2*W + 1);
    localparam logic [CW-1:0] ITERS = CW'(2*W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [2*W-1:0]  r_a;
    logic [W-1:0]    r_p;
    logic [W-1:0]    r_d;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [2*W-1:0]  r_q;
    logic [W-1:0]    r_r;
    logic            r_dz;

    logic [W:0]      w_t;
    logic [W:0]      w_diff;
    logic            w_ge;
    logic [W-1:0]    w_p_next;
    logic [2*W-1:0]  w_a_next;
    logic            w_last;

    // The partial remainder stays below the divisor, so T < 2D and the borrow bit
    // of T - D alone decides T >= D; P therefore fits in W bits.
    always_comb begin
        w_t      = {r_p, r_a[2*W-1]};
        w_diff   = w_t - {1'b0, r_d};
        w_ge     = ~w_diff[W];
        w_p_next = w_ge ? w_diff[W-1:0] : w_t[W-1:0];
        w_a_next = {r_a[2*W-2:0], w_ge};
        w_last   = (r_cnt == CW'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_p     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    r_state <= S_IDLE;
                    if (start) begin
                        r_d <= Y;
                        if (Y == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_q     <= '1;
                            r_r     <= '0;
                            r_dz    <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_a     <= X;
                            r_p     <= '0;
                            r_cnt   <= ITERS;
                        end
                    end
                end
                S_RUN: begin
                    r_a   <= w_a_next;
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_q     <= w_a_next;
                        r_r     <= w_p_next;
                        r_dz    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Q    = r_q;
    assign R    = r_r;
    assign DZ   = r_dz;

endmodule
